// File: rtl/bcd_7seg_scanner_if.sv
// Load-side bus of the 7-segment scanner: three BCD digits plus sign with a
// single-cycle load strobe, and the pending flag reported back to the producer.
interface bcd_7seg_scanner_if;
    logic       load;
    logic [3:0] digito0;
    logic [3:0] digito1;
    logic [3:0] digito2;
    logic       negative;
    logic       pending;

    modport master (
        output load, digito0, digito1, digito2, negative,
        input  pending
    );

    modport slave (
        input  load, digito0, digito1, digito2, negative,
        output pending
    );
endinterface

// File: rtl/bcd_7seg_scanner.sv
// Multiplexed 4-digit common-anode 7-segment driver for a signed 3-digit BCD value.
// Digit 3 shows the sign, digits 2..0 show hundreds, tens and units.
// New values are held in a shadow register and moved to the displayed (active)
// register only at a frame boundary, so a frame never mixes two values.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros of the
// hundreds and tens digits (units always shown).
module bcd_7seg_scanner #(
    parameter int CLK_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_7seg_scanner_if.slave   bus,
    output logic [6:0]          seg,
    output logic [3:0]          an,
    output logic                frame_tick
);

    localparam int              CW    = $clog2(CLK_DIV);
    localparam logic [CW-1:0]   LAST  = CW'(CLK_DIV - 1);
    localparam logic [6:0]      BLANK = 7'h7F;
    localparam logic [6:0]      MINUS = 7'h3F;

    typedef struct packed {
        logic       sign;
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
    } value_t;

    value_t          shadow;
    value_t          active;
    value_t          active_next;
    value_t          incoming;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic [1:0]      index;
    logic [1:0]      index_next;
    logic            pending;
    logic            pending_next;
    logic            slot_end;
    logic            boundary;
    logic [6:0]      digit_seg;
    logic [6:0]      seg_next;
    logic [3:0]      an_next;

    // Segment pattern {g,f,e,d,c,b,a}, active-low; non-BCD codes show 'E'.
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h40;
            4'd1:    p = 7'h79;
            4'd2:    p = 7'h24;
            4'd3:    p = 7'h30;
            4'd4:    p = 7'h19;
            4'd5:    p = 7'h12;
            4'd6:    p = 7'h02;
            4'd7:    p = 7'h78;
            4'd8:    p = 7'h00;
            4'd9:    p = 7'h10;
            default: p = 7'h06;
        endcase
        return p;
    endfunction

    assign incoming    = {bus.negative, bus.digito2, bus.digito1, bus.digito0};
    assign bus.pending = pending;

    // Next scan position and the double-buffer hand-over at the frame boundary.
    always_comb begin
        slot_end     = (count == LAST);
        boundary     = slot_end && (index == 2'd3);
        count_next   = slot_end ? '0 : count + CW'(1);
        index_next   = slot_end ? index + 2'd1 : index;
        active_next  = active;
        pending_next = pending;
        if (boundary) begin
            pending_next = 1'b0;
            if (bus.load) begin
                active_next = incoming;
            end else if (pending) begin
                active_next = shadow;
            end
        end else if (bus.load) begin
            pending_next = 1'b1;
        end
    end

    // Display image for the cycle that follows the next clock edge.
    always_comb begin
        digit_seg = BLANK;
        case (index_next)
            2'd0: digit_seg = decode(active_next.d0);
            2'd1: begin
`ifdef LEADING_ZERO_BLANK_EN
                if (active_next.d2 == 4'd0 && active_next.d1 == 4'd0) begin
                    digit_seg = BLANK;
                end else begin
                    digit_seg = decode(active_next.d1);
                end
`else
                digit_seg = decode(active_next.d1);
`endif
            end
            2'd2: begin
`ifdef LEADING_ZERO_BLANK_EN
                if (active_next.d2 == 4'd0) begin
                    digit_seg = BLANK;
                end else begin
                    digit_seg = decode(active_next.d2);
                end
`else
                digit_seg = decode(active_next.d2);
`endif
            end
            default: digit_seg = active_next.sign ? MINUS : BLANK;
        endcase
        if (count_next == '0) begin
            seg_next = BLANK;
            an_next  = 4'hF;
        end else begin
            seg_next = digit_seg;
            an_next  = ~(4'b0001 << index_next);
        end
    end

    // Scan counters, value registers and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            index      <= 2'd0;
            shadow     <= '0;
            active     <= '0;
            pending    <= 1'b0;
            seg        <= BLANK;
            an         <= 4'hF;
            frame_tick <= 1'b0;
        end else begin
            count      <= count_next;
            index      <= index_next;
            active     <= active_next;
            pending    <= pending_next;
            if (bus.load) begin
                shadow <= incoming;
            end
            seg        <= seg_next;
            an         <= an_next;
            frame_tick <= boundary;
        end
    end

endmodule

// File: doc/bcd_7seg_scanner.md
Name: bcd_7seg_scanner

Overview:
- Downstream of the binary-to-BCD converter. Takes its three BCD digits (units, tens, hundreds) plus a sign flag and drives a 4-digit multiplexed common-anode 7-segment display.
- Digit 3 carries the sign. Digits 2..0 carry hundreds, tens and units.
- New values are double-buffered and applied only at frame boundaries, so the display never shows a torn value.

Parameters:
- CLK_DIV, 50000: clock cycles per digit slot (refresh prescaler). Legal range is 2 or more.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- load  in  1  single-cycle strobe; captures digito0..2 and negative
- digito0  in  4  units BCD digit
- digito1  in  4  tens BCD digit
- digito2  in  4  hundreds BCD digit
- negative  in  1  value is negative (show '-')
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- an  out  4  anode enables, active-low; an[0]=units, an[3]=sign
- frame_tick  out  1  one-cycle pulse when the scan wraps from digit 3 to digit 0
- pending  out  1  a loaded value is waiting for the next frame boundary

Behaviour:
- Clocking and reset:
  - Single clock domain; all outputs registered.
  - Asynchronous reset, active while rst_n is 0.
- Reset values:
  - seg = 7'h7F, an = 4'hF, frame_tick = 0, pending = 0.
  - Prescaler = 0, scan index = 0.
  - Shadow and active registers (3 digits + sign) = 0.
- Prescaler:
  - Counts 0..CLK_DIV-1, then wraps to 0.
  - The terminal count (CLK_DIV-1) is the "slot end".
- Scan index (2-bit):
  - Increments at each slot end; 3 wraps to 0.
  - frame_tick = 1 in the cycle after the 3→0 wrap.
- Anodes:
  - Anti-ghosting: an = 4'hF during prescaler count 0 of every slot.
  - For counts 1..CLK_DIV-1: an = ~(1 << index).
  - After reset release: first cycle blank, then an = 4'b1110 from the second cycle on.
- seg, same registered timing as an:
  - Blank slot cycle: 7'h7F.
  - Index 0..2: decode of the active digit. Standard 0-9 patterns; 0 = 7'h40, 8 = 7'h00.
  - BCD values 10..15: display 'E' = 7'h06.
  - Index 3: '-' = 7'h3F if active sign is 1, else blank 7'h7F.
- Load handshake:
  - On load=1, the inputs are captured into the shadow register and pending is set to 1.
  - load is never back-pressured.
  - Several loads within one frame: the last one wins.
- Frame boundary (slot end while index = 3):
  - If pending: active <= shadow, and pending clears.
  - If load=1 in the same cycle: the incoming inputs go directly to active (newest wins), and pending stays 0.
  - A load in any other cycle is displayed starting at the next frame.
  - Worst-case load-to-display latency is 4*CLK_DIV+1 cycles.
- Mid-operation reset: all state returns to reset values immediately, and any pending value is discarded.
- load is not a reset: it never restarts the prescaler or the index.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Hundreds digit blanked (7'h7F) when active hundreds = 0.
  - Tens digit blanked when hundreds = 0 and tens = 0.
  - Units never blanked.
  - Sign stays on digit 3.
  - Blanking is evaluated on the active register only.
- Not defined: all three digits are always decoded; zeros show as 7'h40.

Test Plan:
- Reset check, CLK_DIV=4: hold rst_n=0 mid-scan → seg=7'h7F, an=4'hF, pending=0 asynchronously. After release: cycle 1 an=4'hF, cycles 2-4 an=4'b1110 with seg=7'h40.
- Scan order and frame_tick, CLK_DIV=4: free run 32 cycles →
  - an pattern per slot is F,E,E,E, F,D,D,D, F,B,B,B, F,7,7,7;
  - frame_tick pulses exactly once every 16 cycles.
- Double buffering: load digits 3,2,1 with negative=1 mid-frame →
  - pending=1 until the frame boundary, then seg shows 7'h30 (units 3), 7'h24 (tens 2), 7'h79 (hundreds 1), 7'h3F (sign);
  - old value remains until the boundary.
- Collision at boundary: load 9,9,9 at the index-3 slot end while pending holds 1,1,1 → next frame shows 9,9,9 (7'h10 each), and pending=0.
- Invalid BCD: load digito0=4'hC → units slot shows 7'h06.
- LEADING_ZERO_BLANK_EN: load 0,0,0 → hundreds and tens blank, units 7'h40. Load 5,0,0 → hundreds and tens blank, units 7'h12. Load 0,0,2 → shows 7'h24,7'h40,7'h40 for hundreds, tens, units.
